// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and constants for the cache fill controller: FSM encoding,
// fill target codes and block geometry helpers.
package cache_fill_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_ISSUE,
    ST_DRAIN,
    ST_TAG
  } state_t;

  localparam logic TGT_I = 1'b0;
  localparam logic TGT_D = 1'b1;

  // Byte-offset bits inside a block for the default 8 x 16-bit geometry.
  localparam int BLK_OFF_W = 4;

  function automatic int idx_w(input int words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_counter.sv
// fill_word_counter: log2(WORDS)-bit word counter with clear, increment,
// start offset (index = start + count, truncated) and terminal count.
module fill_word_counter
  import cache_fill_ctrl_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_start,
  output logic [W-1:0] o_idx,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_inc)   r_cnt <= r_cnt + 1'b1;
  end

  assign o_idx = i_start + r_cnt;
  assign o_tc  = &r_cnt;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Arbitrates I/D misses and write-through stores onto one memory port and
// streams block fills back into the caches. Optional: CRITICAL_WORD_FIRST_EN.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int AWIDTH  = 16,
  parameter int DWIDTH  = 16,
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     icache_miss,
  input  logic [AWIDTH-1:0]        icache_addr,
  input  logic                     dcache_miss,
  input  logic [AWIDTH-1:0]        dcache_addr,
  input  logic                     dcache_wr_req,
  input  logic [AWIDTH-1:0]        dcache_wr_addr,
  input  logic [DWIDTH-1:0]        dcache_wr_data,
  output logic                     mem_enable,
  output logic                     mem_wr,
  output logic [AWIDTH-1:0]        mem_addr,
  output logic [DWIDTH-1:0]        mem_wdata,
  input  logic [DWIDTH-1:0]        mem_rdata,
  input  logic                     mem_data_valid,
  output logic                     fill_target,
  output logic                     fill_busy,
  output logic                     fill_data_we,
  output logic [idx_w(WORDS)-1:0]  fill_word_idx,
  output logic [DWIDTH-1:0]        fill_data,
  output logic                     fill_tag_we,
  output logic [AWIDTH-1:0]        fill_block_addr,
  output logic                     i_fill_done,
  output logic                     d_fill_done,
  output logic                     dcache_wr_ack
);

  localparam int OW = idx_w(WORDS);

  state_t            r_state, w_next;
  logic              r_tgt;
  logic [AWIDTH-1:0] r_addr;
  logic [OW-1:0]     w_start, w_ic_idx, w_rc_idx;
  logic              w_ic_tc, w_rc_tc, w_ret, w_take_miss, w_cnt_clr;
  logic [AWIDTH-1:0] w_base;
  logic              w_unused;

  assign w_take_miss = (r_state == ST_IDLE) && !dcache_wr_req && (dcache_miss || icache_miss);
  // Stray valids outside ISSUE/DRAIN must not disturb the return counter.
  assign w_ret       = ((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) && mem_data_valid;
  assign w_cnt_clr   = !((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
  assign w_base      = {r_addr[AWIDTH-1:OW+1], {(OW+1){1'b0}}};
  assign w_unused    = &{1'b0, r_addr[OW:0], dcache_wr_addr[0]};

`ifdef CRITICAL_WORD_FIRST_EN
  assign w_start = r_addr[OW:1];
`else
  assign w_start = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tgt   <= TGT_I;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (w_take_miss) begin
        r_tgt  <= dcache_miss ? TGT_D : TGT_I;
        r_addr <= dcache_miss ? dcache_addr : icache_addr;
      end
    end
  end

  fill_word_counter #(.W(OW)) u_ic (
    .clk(clk), .rst(rst), .i_clr(w_cnt_clr), .i_inc(r_state == ST_ISSUE),
    .i_start(w_start), .o_idx(w_ic_idx), .o_tc(w_ic_tc)
  );

  fill_word_counter #(.W(OW)) u_rc (
    .clk(clk), .rst(rst), .i_clr(w_cnt_clr), .i_inc(w_ret),
    .i_start(w_start), .o_idx(w_rc_idx), .o_tc(w_rc_tc)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (dcache_wr_req) w_next = ST_WRITE;
                else if (dcache_miss || icache_miss) w_next = ST_ISSUE;
      ST_WRITE: w_next = ST_IDLE;
      ST_ISSUE: if (w_ic_tc) w_next = ST_DRAIN;
      ST_DRAIN: if (w_ret && w_rc_tc) w_next = ST_TAG;
      ST_TAG:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_enable      = 1'b0;
    mem_wr          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    dcache_wr_ack   = 1'b0;
    fill_tag_we     = 1'b0;
    i_fill_done     = 1'b0;
    d_fill_done     = 1'b0;
    fill_busy       = (r_state == ST_ISSUE) || (r_state == ST_DRAIN) || (r_state == ST_TAG);
    fill_target     = r_tgt;
    fill_block_addr = w_base;
    fill_data_we    = w_ret;
    fill_word_idx   = w_ret ? w_rc_idx : '0;
    fill_data       = w_ret ? mem_rdata : '0;
    unique case (r_state)
      ST_WRITE: begin
        mem_enable    = 1'b1;
        mem_wr        = 1'b1;
        mem_addr      = {dcache_wr_addr[AWIDTH-1:1], 1'b0};
        mem_wdata     = dcache_wr_data;
        dcache_wr_ack = 1'b1;
      end
      ST_ISSUE: begin
        mem_enable = 1'b1;
        mem_addr   = w_base | AWIDTH'({w_ic_idx, 1'b0});
      end
      ST_TAG: begin
        fill_tag_we = 1'b1;
        i_fill_done = (r_tgt == TGT_I);
        d_fill_done = (r_tgt == TGT_D);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed self-checking bench for cache_fill_ctrl with a 4-cycle memory
// model whose words hold their own byte address.
module tb_cache_fill_ctrl;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_miss = 0, dcache_miss = 0, dcache_wr_req = 0;
  logic [15:0] icache_addr = 0, dcache_addr = 0, dcache_wr_addr = 0, dcache_wr_data = 0;
  logic        mem_enable, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        fill_target, fill_busy, fill_data_we, fill_tag_we;
  logic [2:0]  fill_word_idx;
  logic [15:0] fill_data, fill_block_addr;
  logic        i_fill_done, d_fill_done, dcache_wr_ack;
  logic        force_valid = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_fill_ctrl #(.AWIDTH(16), .DWIDTH(16), .WORDS(8), .MEM_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
    .dcache_wr_data(dcache_wr_data),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
    .fill_target(fill_target), .fill_busy(fill_busy), .fill_data_we(fill_data_we),
    .fill_word_idx(fill_word_idx), .fill_data(fill_data), .fill_tag_we(fill_tag_we),
    .fill_block_addr(fill_block_addr), .i_fill_done(i_fill_done),
    .d_fill_done(d_fill_done), .dcache_wr_ack(dcache_wr_ack)
  );

  // Memory model: reads return MEM_LAT cycles after the issue cycle; reset flushes.
  logic [15:0]      mem [0:32767];
  logic [3:0]       vpipe;
  logic [3:0][15:0] dpipe;

  always @(posedge clk) begin
    if (rst) begin
      vpipe <= '0;
      dpipe <= '0;
      for (int i = 0; i < 32768; i++) mem[i] <= 16'(i * 2);
    end else begin
      vpipe <= {vpipe[2:0], mem_enable & ~mem_wr};
      dpipe <= {dpipe[2:0], mem[mem_addr[15:1]]};
      if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_wdata;
    end
  end

  assign mem_data_valid = vpipe[3] | force_valid;
  assign mem_rdata      = dpipe[3];

  function automatic logic [2:0] exp_start(input logic [15:0] a);
    return CWF ? a[3:1] : 3'd0;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({mem_enable, mem_wr, mem_addr, mem_wdata, fill_target, fill_busy, fill_data_we,
         fill_word_idx, fill_data, fill_tag_we, fill_block_addr, i_fill_done,
         d_fill_done, dcache_wr_ack} !== 76'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: mem_en=%b busy=%b addr=%h blk=%h", mem_enable, fill_busy, mem_addr, fill_block_addr);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_imiss;
    logic [2:0]  s, k;
    logic [15:0] e;
    s = exp_start(16'h1234);
    @(posedge clk); #1 icache_miss = 1'b1; icache_addr = 16'h1234;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      n_chk++;
      if (mem_enable !== (c >= 1 && c <= 8)) begin
        n_fail++; $display("FAIL imiss_mem_en c=%0d got=%b", c, mem_enable);
      end
      if (c >= 1 && c <= 8) begin
        k = s + 3'(c - 1); e = 16'h1230 | {12'h0, k, 1'b0};
        n_chk++;
        if (mem_addr !== e || mem_wr !== 1'b0) begin
          n_fail++; $display("FAIL imiss_addr c=%0d got=%h wr=%b exp=%h", c, mem_addr, mem_wr, e);
        end
      end
      n_chk++;
      if (fill_data_we !== (c >= 5 && c <= 12)) begin
        n_fail++; $display("FAIL imiss_we c=%0d got=%b", c, fill_data_we);
      end
      if (c >= 5 && c <= 12) begin
        k = s + 3'(c - 5); e = 16'h1230 | {12'h0, k, 1'b0};
        n_chk++;
        if (fill_word_idx !== k || fill_data !== e) begin
          n_fail++; $display("FAIL imiss_ret c=%0d idx=%0d data=%h exp idx=%0d data=%h", c, fill_word_idx, fill_data, k, e);
        end
      end
      n_chk++;
      if (fill_busy !== (c >= 1 && c <= 13)) begin
        n_fail++; $display("FAIL imiss_busy c=%0d got=%b", c, fill_busy);
      end
      n_chk++;
      if ({fill_tag_we, i_fill_done, d_fill_done} !== ((c == 13) ? 3'b110 : 3'b000)) begin
        n_fail++; $display("FAIL imiss_done c=%0d got tag/i/d=%b%b%b", c, fill_tag_we, i_fill_done, d_fill_done);
      end
      if (c == 13) begin
        n_chk++;
        if (fill_block_addr !== 16'h1230 || fill_target !== 1'b0) begin
          n_fail++; $display("FAIL imiss_blk got=%h tgt=%b exp=1230/0", fill_block_addr, fill_target);
        end
        icache_miss = 1'b0;
      end
    end
  endtask

  task automatic test_d_then_i;
    bit done;
    @(posedge clk); #1
    dcache_miss = 1'b1; dcache_addr = 16'h2000;
    icache_miss = 1'b1; icache_addr = 16'h3000;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_chk++;
        if (fill_target !== 1'b1 || fill_busy !== 1'b1) begin
          n_fail++; $display("FAIL dthen_i_tgt_d got tgt=%b busy=%b exp 1/1", fill_target, fill_busy);
        end
      end
      if (c == 13) begin
        n_chk++;
        if ({d_fill_done, i_fill_done} !== 2'b10) begin
          n_fail++; $display("FAIL dthen_i_ddone got d/i=%b%b exp 10", d_fill_done, i_fill_done);
        end
        dcache_miss = 1'b0;
      end
      if (c == 14) begin
        n_chk++;
        if (fill_busy !== 1'b0) begin
          n_fail++; $display("FAIL dthen_i_idle got busy=%b exp 0", fill_busy);
        end
      end
    end
    @(negedge clk);
    n_chk++;
    if (fill_busy !== 1'b1 || fill_target !== 1'b0 || mem_addr !== 16'h3000) begin
      n_fail++; $display("FAIL dthen_i_istart got busy=%b tgt=%b addr=%h exp 1/0/3000", fill_busy, fill_target, mem_addr);
    end
    done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (i_fill_done) begin done = 1'b1; icache_miss = 1'b0; break; end
    end
    n_chk++;
    if (!done) begin n_fail++; $display("FAIL dthen_i_idone got=0 exp=1"); end
    if (!done) icache_miss = 1'b0;
  endtask

  task automatic test_store_miss;
    bit          done, got1;
    int          acks;
    logic [15:0] w1;
    @(posedge clk); #1
    dcache_wr_req = 1'b1; dcache_wr_addr = 16'h0042; dcache_wr_data = 16'hBEEF;
    dcache_miss = 1'b1; dcache_addr = 16'h0040;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({mem_enable, mem_wr, dcache_wr_ack, fill_busy} !== 4'b1110 ||
        mem_addr !== 16'h0042 || mem_wdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL store_write got en/wr/ack/busy=%b%b%b%b addr=%h data=%h", mem_enable, mem_wr, dcache_wr_ack, fill_busy, mem_addr, mem_wdata);
    end
    dcache_wr_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({mem_enable, dcache_wr_ack, fill_busy} !== 3'b000) begin
      n_fail++; $display("FAIL store_idle got en/ack/busy=%b%b%b exp 000", mem_enable, dcache_wr_ack, fill_busy);
    end
    @(negedge clk);
    n_chk++;
    if (fill_busy !== 1'b1 || fill_target !== 1'b1 || mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL store_dfill_start got busy=%b tgt=%b wr=%b", fill_busy, fill_target, mem_wr);
    end
    done = 1'b0; got1 = 1'b0; acks = 0; w1 = 16'h0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dcache_wr_ack) acks++;
      if (fill_data_we && fill_word_idx == 3'd1) begin got1 = 1'b1; w1 = fill_data; end
      if (d_fill_done) begin
        done = 1'b1;
        n_chk++;
        if (fill_block_addr !== 16'h0040) begin
          n_fail++; $display("FAIL store_blk got=%h exp=0040", fill_block_addr);
        end
        dcache_miss = 1'b0;
        break;
      end
    end
    dcache_miss = 1'b0;
    n_chk++;
    if (!done || !got1 || w1 !== 16'hBEEF) begin
      n_fail++; $display("FAIL store_readback done=%b seen=%b word1=%h exp=beef", done, got1, w1);
    end
    n_chk++;
    if (acks !== 0) begin n_fail++; $display("FAIL store_extra_ack got=%0d exp=0", acks); end
  endtask

  task automatic test_idle_valid;
    @(posedge clk); #1 force_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (fill_data_we !== 1'b0 || fill_busy !== 1'b0) begin
        n_fail++; $display("FAIL idle_valid c=%0d we=%b busy=%b exp 0/0", c, fill_data_we, fill_busy);
      end
    end
    @(posedge clk); #1 force_valid = 1'b0;
  endtask

  task automatic test_cwf;
    logic [2:0]  s, k;
    logic [15:0] e;
    s = exp_start(16'h001A);
    @(posedge clk); #1 icache_miss = 1'b1; icache_addr = 16'h001A;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 8) begin
        k = s + 3'(c - 1); e = {12'h001, k, 1'b0};
        n_chk++;
        if (mem_addr !== e) begin
          n_fail++; $display("FAIL cwf_addr c=%0d got=%h exp=%h", c, mem_addr, e);
        end
      end
      if (c >= 5 && c <= 12) begin
        k = s + 3'(c - 5); e = {12'h001, k, 1'b0};
        n_chk++;
        if (fill_data_we !== 1'b1 || fill_word_idx !== k || fill_data !== e) begin
          n_fail++; $display("FAIL cwf_ret c=%0d we=%b idx=%0d data=%h exp idx=%0d data=%h", c, fill_data_we, fill_word_idx, fill_data, k, e);
        end
      end
      if (c == 13) begin
        n_chk++;
        if (i_fill_done !== 1'b1 || fill_block_addr !== 16'h0010) begin
          n_fail++; $display("FAIL cwf_done got=%b blk=%h exp 1/0010", i_fill_done, fill_block_addr);
        end
        icache_miss = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid;
    bit         done;
    int         nwe;
    logic [2:0] s, k;
    @(posedge clk); #1 icache_miss = 1'b1; icache_addr = 16'h0100;
    for (int c = 0; c < 8; c++) @(negedge clk);
    rst = 1'b1; icache_miss = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({mem_enable, mem_wr, mem_addr, mem_wdata, fill_target, fill_busy, fill_data_we,
         fill_word_idx, fill_data, fill_tag_we, fill_block_addr, i_fill_done,
         d_fill_done, dcache_wr_ack} !== 76'd0) begin
      n_fail++; $display("FAIL rstmid_outputs en=%b busy=%b addr=%h blk=%h", mem_enable, fill_busy, mem_addr, fill_block_addr);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_chk++;
      if ({i_fill_done, d_fill_done, fill_data_we, fill_busy} !== 4'b0000) begin
        n_fail++; $display("FAIL rstmid_quiet c=%0d got done_i/done_d/we/busy=%b%b%b%b", c, i_fill_done, d_fill_done, fill_data_we, fill_busy);
      end
    end
    s = exp_start(16'h0208);
    @(posedge clk); #1 icache_miss = 1'b1; icache_addr = 16'h0208;
    done = 1'b0; nwe = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fill_data_we) begin
        k = s + 3'(nwe);
        n_chk++;
        if (fill_word_idx !== k || fill_data !== {12'h020, k, 1'b0}) begin
          n_fail++; $display("FAIL rstmid_refill n=%0d idx=%0d data=%h exp idx=%0d", nwe, fill_word_idx, fill_data, k);
        end
        nwe++;
      end
      if (i_fill_done) begin done = 1'b1; break; end
    end
    icache_miss = 1'b0;
    n_chk++;
    if (!done || nwe != 8) begin
      n_fail++; $display("FAIL rstmid_refill_done done=%b words=%0d exp 1/8", done, nwe);
    end
  endtask

  initial begin
    test_reset();
    test_imiss();
    test_d_then_i();
    test_store_miss();
    test_idle_valid();
    test_cwf();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
